// File: rtl/multiplier_pkg.sv
// Shared width and state definitions for the modular-arithmetic blocks.
package multiplier_pkg;

  parameter int unsigned DATA_LENGTH = 64;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StShift,
    StDone
  } mont_to_form_state_t;

endpackage

// File: rtl/montgomery_to_form_mod_double_sub.sv
// Combinational conditional double-and-subtract: t_next = (2t >= m) ? 2t - m : 2t.
module mod_double_sub #(
  parameter int unsigned DATA_LENGTH = multiplier_pkg::DATA_LENGTH
) (
  input  logic [DATA_LENGTH-1:0] t_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  output logic [DATA_LENGTH-1:0] t_next_o
);

  logic [DATA_LENGTH:0]   u;
  logic [DATA_LENGTH+1:0] diff;

  // One subtractor doubles as the comparator: its borrow bit says u < m.
  always_comb begin
    u        = {t_i, 1'b0};
    diff     = {1'b0, u} - {2'b00, m_i};
    t_next_o = diff[DATA_LENGTH+1] ? u[DATA_LENGTH-1:0] : diff[DATA_LENGTH-1:0];
  end

endmodule

// File: rtl/montgomery_to_form.sv
// Converts x to Montgomery form x*2^k mod m by k serial double-and-subtract steps.
module montgomery_to_form #(
  parameter int unsigned DATA_LENGTH = multiplier_pkg::DATA_LENGTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o,
  output logic                   err_o,
  output logic                   busy_o
);

  import multiplier_pkg::*;

  localparam logic [DATA_LENGTH-1:0] MaxBl = DATA_LENGTH'(DATA_LENGTH);
  localparam logic [DATA_LENGTH-1:0] One   = DATA_LENGTH'(1);

  mont_to_form_state_t   state_q;
  logic [DATA_LENGTH-1:0] x_q, m_q, m_bl_q, t_q, cnt_q;
  logic [DATA_LENGTH-1:0] t_next;

  mod_double_sub #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_mod_double_sub (
    .t_i     (t_q),
    .m_i     (m_q),
    .t_next_o(t_next)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      x_q      <= '0;
      m_q      <= '0;
      m_bl_q   <= '0;
      t_q      <= '0;
      cnt_q    <= '0;
      result_o <= '0;
      valid_o  <= 1'b0;
      err_o    <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            x_q     <= x_i;
            m_q     <= m_i;
            m_bl_q  <= m_bl_i;
            busy_o  <= 1'b1;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (m_q == '0 || m_bl_q > MaxBl || x_q >= m_q) begin
            result_o <= '0;
            err_o    <= 1'b1;
            valid_o  <= 1'b1;
            state_q  <= StDone;
          end else if (m_bl_q == '0) begin
            // R = 1: the operand is already in Montgomery form.
            t_q      <= x_q;
            result_o <= x_q;
            err_o    <= 1'b0;
            valid_o  <= 1'b1;
            state_q  <= StDone;
          end else begin
            t_q     <= x_q;
            cnt_q   <= m_bl_q;
            state_q <= StShift;
          end
        end
        StShift: begin
          t_q   <= t_next;
          cnt_q <= cnt_q - One;
          if (cnt_q == One) begin
            result_o <= t_next;
            err_o    <= 1'b0;
            valid_o  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          valid_o <= 1'b0;
          err_o   <= 1'b0;
          busy_o  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_to_form.sv
// Self-checking bench for montgomery_to_form: directed corner cases plus random round trips.
module tb_montgomery_to_form;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] x, m, mbl;
  logic [63:0] result;
  logic        valid, err, busy;

  int total = 0;
  int bad   = 0;

  montgomery_to_form #(
    .DATA_LENGTH(64)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .x_i     (x),
    .m_i     (m),
    .m_bl_i  (mbl),
    .result_o(result),
    .valid_o (valid),
    .err_o   (err),
    .busy_o  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: x * 2^k mod m with wide arithmetic.
  function automatic logic [63:0] to_form(input logic [63:0] xv, input logic [63:0] mv,
                                          input logic [63:0] kv);
    logic [127:0] v;
    v = {64'd0, xv} << kv[6:0];
    return 64'(v % {64'd0, mv});
  endfunction

  // Inverse conversion (bit-serial Montgomery reduction y * 2^-k mod m, m odd).
  function automatic logic [63:0] from_form(input logic [63:0] y, input logic [63:0] mv,
                                            input int k);
    logic [64:0] a;
    a = {1'b0, y};
    for (int i = 0; i < k; i++) begin
      if (a[0]) a = a + {1'b0, mv};
      a = a >> 1;
    end
    return a[63:0];
  endfunction

  // Starts one conversion from IDLE and waits (bounded) for valid.
  task automatic run(input logic [63:0] xv, input logic [63:0] mv, input logic [63:0] bv,
                     output logic [63:0] res, output logic e, output int lat,
                     output logic busy_ok);
    @(negedge clk);
    x = xv; m = mv; mbl = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end while (valid !== 1'b1 && lat < 200);
    res = result;
    e   = err;
  endtask

  // One edge after DONE: valid/err clear, result holds, back in IDLE.
  task automatic check_after(input string tag, input logic [63:0] held);
    @(posedge clk);
    #1;
    check({tag, "_valid_clr"}, 64'(valid), 64'd0);
    check({tag, "_err_clr"}, 64'(err), 64'd0);
    check({tag, "_hold"}, result, held);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  logic [63:0] res, mv, xv, r, mask;
  logic        e, bok, quiet;
  int          lat, bl;

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; m = '0; mbl = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b0;

    run(64'd5, 64'd13, 64'd4, res, e, lat, bok);
    check("basic_res", res, 64'd2);
    check("basic_err", 64'(e), 64'd0);
    check("basic_lat", 64'(lat), 64'd5);
    check("basic_busy", 64'(bok), 64'd1);
    check_after("basic", 64'd2);

    run(64'hFFFF_FFFF_FFFF_FFC4, 64'hFFFF_FFFF_FFFF_FFC5, 64'd64, res, e, lat, bok);
    check("wide_res", res, 64'hFFFF_FFFF_FFFF_FF8A);
    check("wide_err", 64'(e), 64'd0);
    check("wide_lat", 64'(lat), 64'd65);
    check_after("wide", 64'hFFFF_FFFF_FFFF_FF8A);

    run(64'd13, 64'd13, 64'd4, res, e, lat, bok);
    check("xgem_err", 64'(e), 64'd1);
    check("xgem_res", res, 64'd0);
    check("xgem_lat", 64'(lat), 64'd1);
    check_after("xgem", 64'd0);

    run(64'd5, 64'd0, 64'd4, res, e, lat, bok);
    check("mzero_err", 64'(e), 64'd1);
    check("mzero_res", res, 64'd0);
    @(posedge clk);

    run(64'd5, 64'd13, 64'd65, res, e, lat, bok);
    check("bl65_err", 64'(e), 64'd1);
    check("bl65_lat", 64'(lat), 64'd1);
    @(posedge clk);

    run(64'd0, 64'd13, 64'd4, res, e, lat, bok);
    check("xzero_res", res, 64'd0);
    check("xzero_err", 64'(e), 64'd0);
    @(posedge clk);

    run(64'd7, 64'd13, 64'd0, res, e, lat, bok);
    check("bl0_res", res, 64'd7);
    check("bl0_err", 64'(e), 64'd0);
    check("bl0_lat", 64'(lat), 64'd1);
    @(posedge clk);

    // Abort after the 2nd SHIFT edge: outputs clear at once, no residue afterwards.
    @(negedge clk);
    x = 64'd5; m = 64'd13; mbl = 64'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_result", result, 64'd0);
    check("abort_valid", 64'(valid), 64'd0);
    check("abort_err", 64'(err), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk) rst = 1'b0;
    run(64'd5, 64'd13, 64'd4, res, e, lat, bok);
    check("post_rst_res", res, 64'd2);
    check("post_rst_lat", 64'(lat), 64'd5);
    check_after("post_rst", 64'd2);

    // Second start and changed operands while busy must be ignored.
    @(negedge clk);
    x = 64'd5; m = 64'd13; mbl = 64'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        x = 64'd1; m = 64'd7; mbl = 64'd3; start = 1'b1;
      end else if (lat == 2) begin
        start = 1'b0;
      end
    end while (valid !== 1'b1 && lat < 200);
    check("midchg_res", result, 64'd2);
    check("midchg_lat", 64'(lat), 64'd5);
    quiet = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    check("midchg_no_queue", 64'(quiet), 64'd1);

    // Random legal operands: compare with the reference and invert the conversion.
    for (int n = 0; n < 200; n++) begin
      bl   = int'($urandom_range(1, 64));
      r    = {$urandom, $urandom};
      mask = (bl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bl) - 64'd1);
      mv   = (r & mask) | (64'd1 << (bl - 1)) | 64'd1;
      xv   = {$urandom, $urandom} % mv;
      run(xv, mv, 64'(bl), res, e, lat, bok);
      check("rand_res", res, to_form(xv, mv, 64'(bl)));
      check("rand_err", 64'(e), 64'd0);
      check("rand_trip", from_form(res, mv, bl), xv);
      @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
